// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2), opcode decode, per-class execute states.
// Strobes are decoded from the state register, the read-wait counter and the opcode class.
module control_sequencer #(
  parameter int unsigned READ_WAIT = 0,
  parameter int unsigned OPW       = 5
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        IncrementPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        Cout,
  output logic        HIin,
  output logic        LOin,
  output logic        Run,
  output logic        Illegal,
  output logic [4:0]  State
);

  localparam int unsigned CNT_W = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] RW_INIT = CNT_W'(READ_WAIT);

  typedef enum logic [4:0] {
    S_RST  = 5'd0,
    S_T0   = 5'd1,
    S_T1   = 5'd2,
    S_T2   = 5'd3,
    S_T3   = 5'd4,
    S_T4   = 5'd5,
    S_T5   = 5'd6,
    S_T6   = 5'd7,
    S_T7   = 5'd8,
    S_HALT = 5'd31
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_NEGNOT, C_NOP, C_HALT, C_ILL
  } cls_t;

  state_t           state;
  cls_t             cls;
  logic [CNT_W-1:0] wait_cnt;
  logic [OPW-1:0]   opcode;
  logic             read_done;
  logic             unused_ir;

  assign opcode    = IR[31 -: OPW];
  assign unused_ir = ^IR[31-OPW:0];
  assign read_done = (wait_cnt == '0);
  assign State     = state;

  // Opcode class decode; anything not listed is illegal.
  always_comb begin
    cls = C_ILL;
    if (opcode == OPW'(0))                              cls = C_LD;
    else if (opcode == OPW'(1))                         cls = C_LDI;
    else if (opcode == OPW'(2))                         cls = C_ST;
    else if (opcode <= OPW'(12))                        cls = C_ALU;
    else if (opcode <= OPW'(15))                        cls = C_IMM;
    else if (opcode <= OPW'(17))                        cls = C_MULDIV;
    else if (opcode <= OPW'(19))                        cls = C_NEGNOT;
    else if (opcode == OPW'(26))                        cls = C_NOP;
    else if (opcode == OPW'(27))                        cls = C_HALT;
  end

  // State register and read-wait counter.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state    <= S_RST;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_RST: state <= S_T0;
        S_T0: begin
          state    <= S_T1;
          wait_cnt <= RW_INIT;
        end
        S_T1: begin
          if (!read_done) wait_cnt <= wait_cnt - CNT_W'(1);
          else            state    <= S_T2;
        end
        S_T2: begin
          if (cls == C_NOP)       state <= S_T0;
          else if (cls == C_HALT) state <= S_HALT;
          else                    state <= S_T3;
        end
        S_T3: state <= (cls == C_ILL) ? S_T0 : S_T4;
        S_T4: state <= (cls == C_NEGNOT) ? S_T0 : S_T5;
        S_T5: begin
          if (cls == C_LD || cls == C_ST || cls == C_MULDIV) begin
            state    <= S_T6;
            wait_cnt <= RW_INIT;
          end else begin
            state <= S_T0;
          end
        end
        S_T6: begin
          if (cls == C_LD) begin
            if (!read_done) wait_cnt <= wait_cnt - CNT_W'(1);
            else            state    <= S_T7;
          end else if (cls == C_ST) begin
            state <= S_T7;
          end else begin
            state <= S_T0;
          end
        end
        S_T7:   state <= S_T0;
        S_HALT: state <= S_HALT;
        default: state <= S_RST;
      endcase
    end
  end

  // Moore strobe decode: exactly one bus driver at most per state.
  always_comb begin
    PCout = 1'b0; IncrementPC = 1'b0; MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    IRin = 1'b0; Read = 1'b0; Write = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Yin = 1'b0; Zin = 1'b0; ZLOout = 1'b0;
    ZHIout = 1'b0; Cout = 1'b0; HIin = 1'b0; LOin = 1'b0; Illegal = 1'b0;
    Run = (state != S_HALT);
    case (state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncrementPC = 1'b1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = read_done;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        case (cls)
          C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_ALU, C_IMM:      begin Grb = 1'b1; Rout  = 1'b1; Yin = 1'b1; end
          C_MULDIV:          begin Gra = 1'b1; Rout  = 1'b1; Yin = 1'b1; end
          C_NEGNOT:          begin Grb = 1'b1; Rout  = 1'b1; Zin = 1'b1; end
          C_ILL:             Illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_LD, C_LDI, C_ST, C_IMM: begin Cout = 1'b1; Zin = 1'b1; end
          C_ALU:    begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
          C_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
          C_NEGNOT: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_LD, C_ST:          begin ZLOout = 1'b1; MARin = 1'b1; end
          C_LDI, C_ALU, C_IMM: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_MULDIV:            begin ZLOout = 1'b1; LOin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_LD:     begin Read = 1'b1; MDRin = read_done; end
          C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          C_MULDIV: begin ZHIout = 1'b1; HIin = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST:    Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: two instances (READ_WAIT 0 and 2) checked
// cycle by cycle against per-instruction expected strobe schedules.
module tb_control_sequencer;

  localparam logic [22:0] PCO  = 23'h400000, INC  = 23'h200000, MARI = 23'h100000;
  localparam logic [22:0] MDRI = 23'h080000, MDRO = 23'h040000, IRI  = 23'h020000;
  localparam logic [22:0] RD   = 23'h010000, WR   = 23'h008000, GRA  = 23'h004000;
  localparam logic [22:0] GRB  = 23'h002000, GRC  = 23'h001000, RIN  = 23'h000800;
  localparam logic [22:0] ROUT = 23'h000400, BAO  = 23'h000200, YIN  = 23'h000100;
  localparam logic [22:0] ZIN  = 23'h000080, ZLO  = 23'h000040, ZHI  = 23'h000020;
  localparam logic [22:0] COUT = 23'h000010, HIIN = 23'h000008, LOIN = 23'h000004;
  localparam logic [22:0] RUN  = 23'h000002, ILL  = 23'h000001;
  localparam logic [22:0] OUTM = PCO | MDRO | ROUT | BAO | ZLO | ZHI | COUT;
  localparam logic [27:0] RSTV = {5'd0, RUN};
  localparam logic [27:0] T0V  = {5'd1, PCO | MARI | INC | RUN};
  localparam logic [27:0] HLTV = {5'd31, 23'h0};

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] ir0 = {5'd26, 27'd0};
  logic [31:0] ir2 = {5'd26, 27'd0};
  wire  [22:0] s0, s2;
  wire  [4:0]  st0, st2;
  int          n_chk = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [27:0] expq[$];

  always #5 clk = ~clk;

  control_sequencer #(.READ_WAIT(0), .OPW(5)) u_dut0 (
    .Clock(clk), .Clear(clear), .IR(ir0),
    .PCout(s0[22]), .IncrementPC(s0[21]), .MARin(s0[20]), .MDRin(s0[19]), .MDRout(s0[18]),
    .IRin(s0[17]), .Read(s0[16]), .Write(s0[15]), .Gra(s0[14]), .Grb(s0[13]), .Grc(s0[12]),
    .Rin(s0[11]), .Rout(s0[10]), .BAout(s0[9]), .Yin(s0[8]), .Zin(s0[7]), .ZLOout(s0[6]),
    .ZHIout(s0[5]), .Cout(s0[4]), .HIin(s0[3]), .LOin(s0[2]), .Run(s0[1]), .Illegal(s0[0]),
    .State(st0)
  );

  control_sequencer #(.READ_WAIT(2), .OPW(5)) u_dut2 (
    .Clock(clk), .Clear(clear), .IR(ir2),
    .PCout(s2[22]), .IncrementPC(s2[21]), .MARin(s2[20]), .MDRin(s2[19]), .MDRout(s2[18]),
    .IRin(s2[17]), .Read(s2[16]), .Write(s2[15]), .Gra(s2[14]), .Grb(s2[13]), .Grc(s2[12]),
    .Rin(s2[11]), .Rout(s2[10]), .BAout(s2[9]), .Yin(s2[8]), .Zin(s2[7]), .ZLOout(s2[6]),
    .ZHIout(s2[5]), .Cout(s2[4]), .HIin(s2[3]), .LOin(s2[2]), .Run(s2[1]), .Illegal(s2[0]),
    .State(st2)
  );

  task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] obs(input bit sel);
    return sel ? {st2, s2} : {st0, s0};
  endfunction

  function automatic logic [27:0] ent(input int st, input logic [22:0] m);
    return {5'(st), (st == 31) ? m : (m | RUN)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle (state, strobes) schedule for one instruction, from T0 onward.
  function automatic void build_seq(input int op, input int rw);
    expq.delete();
    expq.push_back(ent(1, PCO | MARI | INC));
    for (int i = 0; i < rw; i++) expq.push_back(ent(2, RD));
    expq.push_back(ent(2, RD | MDRI));
    expq.push_back(ent(3, MDRO | IRI));
    if (op == 26 || op == 27) return;
    if (op <= 2) begin
      expq.push_back(ent(4, GRB | BAO | YIN));
      expq.push_back(ent(5, COUT | ZIN));
      if (op == 1) begin
        expq.push_back(ent(6, ZLO | GRA | RIN));
      end else begin
        expq.push_back(ent(6, ZLO | MARI));
        if (op == 0) begin
          for (int i = 0; i < rw; i++) expq.push_back(ent(7, RD));
          expq.push_back(ent(7, RD | MDRI));
          expq.push_back(ent(8, MDRO | GRA | RIN));
        end else begin
          expq.push_back(ent(7, GRA | ROUT | MDRI));
          expq.push_back(ent(8, WR));
        end
      end
    end else if (op <= 15) begin
      expq.push_back(ent(4, GRB | ROUT | YIN));
      expq.push_back(ent(5, (op <= 12) ? (GRC | ROUT | ZIN) : (COUT | ZIN)));
      expq.push_back(ent(6, ZLO | GRA | RIN));
    end else if (op <= 17) begin
      expq.push_back(ent(4, GRA | ROUT | YIN));
      expq.push_back(ent(5, GRB | ROUT | ZIN));
      expq.push_back(ent(6, ZLO | LOIN));
      expq.push_back(ent(7, ZHI | HIIN));
    end else if (op <= 19) begin
      expq.push_back(ent(4, GRB | ROUT | ZIN));
      expq.push_back(ent(5, ZLO | GRA | RIN));
    end else begin
      expq.push_back(ent(4, ILL));
    end
  endfunction

  task automatic clear_seq(input int n);
    clear = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      chk("clr.rst0", obs(1'b0), RSTV);
      chk("clr.rst2", obs(1'b1), RSTV);
    end
    clear = 1'b0;
    step();
    chk("clr.t0_0", obs(1'b0), T0V);
    chk("clr.t0_2", obs(1'b1), T0V);
  endtask

  // Runs one instruction on the selected instance, which must be in T0 on entry.
  task automatic run_instr(input bit sel, input int op, input int abort_at, input int halt_hold);
    logic [31:0] w;
    w = {5'(op), 27'($urandom)};
    if (sel) ir2 = w; else ir0 = w;
    build_seq(op, sel ? 2 : 0);
    for (int i = 0; i < expq.size(); i++) begin
      chk($sformatf("rw%0d.op%0d.c%0d", sel ? 2 : 0, op, i), obs(sel), expq[i]);
      if (i == abort_at) begin
        clear = 1'b1;
        step();
        chk("abort.rst", obs(sel), RSTV);
        clear = 1'b0;
        step();
        chk("abort.t0", obs(sel), T0V);
        return;
      end
      step();
    end
    if (op == 27) begin
      for (int j = 0; j < halt_hold; j++) begin
        chk("halt.hold", obs(sel), HLTV);
        step();
      end
      clear_seq(1);
      return;
    end
    chk($sformatf("rw%0d.op%0d.ret", sel ? 2 : 0, op), obs(sel), T0V);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("bus0", 28'($countones(s0 & OUTM) > 1), 28'd0);
      chk("bus2", 28'($countones(s2 & OUTM) > 1), 28'd0);
    end
  end

  initial begin
    clear_seq(3);
    mon_en = 1'b1;

    run_instr(1'b0, 3, -1, 0);
    run_instr(1'b0, 27, -1, 20);
    run_instr(1'b0, 31, -1, 0);
    run_instr(1'b0, 26, -1, 0);
    for (int k = 0; k < 40; k++) begin
      int op;
      op = int'($urandom_range(0, 31));
      run_instr(1'b0, op, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 11)) : -1,
                int'($urandom_range(1, 5)));
    end

    ir0 = {5'd26, 27'd0};
    clear_seq(1);
    run_instr(1'b1, 0, -1, 0);
    run_instr(1'b1, 16, 7, 0);
    run_instr(1'b1, 3, -1, 0);
    run_instr(1'b1, 17, -1, 0);
    for (int k = 0; k < 40; k++) begin
      int op;
      op = int'($urandom_range(0, 31));
      run_instr(1'b1, op, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 13)) : -1,
                int'($urandom_range(1, 5)));
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
